// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a first-word fall-through receive FIFO.
//   Optional line-break detector enabled by defining UART_RX_BREAK_EN.
//   clk, rst (async, active-high)  system clock and reset
//   rxd                            serial input, idle high, asynchronous
//   d_rx, vld_rx, rdy_rx           FIFO head character / non-empty / consumer ready (pop on vld_rx && rdy_rx)
//   count                          FIFO occupancy
//   err_frame, err_parity          one-cycle error pulses
//   overrun, clr_err               sticky dropped-character flag and its clear
//   brk                            line-break indication (0 unless UART_RX_BREAK_EN)
module uart_rx_fifo #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVS        = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    output logic [DATA_BITS-1:0]          d_rx,
    output logic                          vld_rx,
    input  logic                          rdy_rx,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          err_frame,
    output logic                          err_parity,
    output logic                          overrun,
    input  logic                          clr_err,
    output logic                          brk
);
    localparam int DIV_R = (CLK_HZ + BAUD * OVS / 2) / (BAUD * OVS);
    localparam int DIV   = DIV_R < 1 ? 1 : DIV_R;
    localparam int DW    = DIV > 1 ? $clog2(DIV) : 1;
    localparam int PW    = $clog2(OVS);
    localparam int IW    = $clog2(DATA_BITS);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HI} state_t;

    state_t               state_q, state_d;
    logic                 s1_q, s2_q, rx;
    logic [DW-1:0]        div_q, div_d;
    logic [PW-1:0]        ph_q, ph_d;
    logic [IW-1:0]        bi_q, bi_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 pok_q, pok_d, push_q, push_d, ef_q, ef_d, ep_q, ep_d;
    logic                 tick, samp;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATA_BITS-1:0] d_rx_q, d_rx_d;
    logic                 ovr_q, ovr_d, full, pop, wr;

    assign rx = s2_q;

    always_comb begin
        tick    = div_q == DW'(DIV - 1);
        samp    = tick && ph_q == PW'(OVS - 1);
        div_d   = tick ? '0 : div_q + 1'b1;
        state_d = state_q;
        ph_d    = tick ? (samp ? '0 : ph_q + 1'b1) : ph_q;
        bi_d    = bi_q;
        sh_d    = sh_q;
        pok_d   = pok_q;
        push_d  = 1'b0;
        ef_d    = 1'b0;
        ep_d    = 1'b0;
        case (state_q)
            IDLE: if (!rx) begin
                state_d = START;
                ph_d    = '0;
            end
            // Mid-bit of the start bit re-aligns the phase so later samples land mid-bit.
            START: if (tick && ph_q == PW'(OVS / 2 - 1)) begin
                ph_d    = '0;
                bi_d    = '0;
                pok_d   = 1'b1;
                state_d = rx ? IDLE : DATA;
            end
            DATA: if (samp) begin
                sh_d = {rx, sh_q[DATA_BITS-1:1]};
                bi_d = bi_q + 1'b1;
                if (bi_q == IW'(DATA_BITS - 1)) state_d = PARITY != 0 ? PAR : STOP;
            end
            PAR: if (samp) begin
                pok_d   = rx == ((^sh_q) ^ (PARITY == 1));
                state_d = STOP;
            end
            STOP: if (samp) begin
                push_d  = rx && pok_q;
                ep_d    = rx && !pok_q;
                ef_d    = !rx;
                state_d = rx ? IDLE : WAIT_HI;
            end
            WAIT_HI: if (rx) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        full  = cnt_q == CW'(FIFO_DEPTH);
        pop   = vld_rx && rdy_rx;
        wr    = push_q && (!full || pop);
        wp_d  = wp_q + AW'(wr);
        rp_d  = rp_q + AW'(pop);
        cnt_d = cnt_q + CW'(wr) - CW'(pop);
        ovr_d = (push_q && full && !pop) ? 1'b1 : (clr_err ? 1'b0 : ovr_q);
        // A write into the slot that becomes the head must bypass the memory read.
        d_rx_d = cnt_d == '0 ? d_rx_q : ((wr && wp_q == rp_d) ? sh_q : mem_q[rp_d]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            state_q <= IDLE;
            div_q   <= '0;
            ph_q    <= '0;
            bi_q    <= '0;
            sh_q    <= '0;
            pok_q   <= 1'b1;
            push_q  <= 1'b0;
            ef_q    <= 1'b0;
            ep_q    <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            d_rx_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            s1_q    <= rxd;
            s2_q    <= s1_q;
            state_q <= state_d;
            div_q   <= div_d;
            ph_q    <= ph_d;
            bi_q    <= bi_d;
            sh_q    <= sh_d;
            pok_q   <= pok_d;
            push_q  <= push_d;
            ef_q    <= ef_d;
            ep_q    <= ep_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            d_rx_q  <= d_rx_d;
            ovr_q   <= ovr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q] <= sh_q;
    end

    assign d_rx       = d_rx_q;
    assign vld_rx     = cnt_q != '0;
    assign count      = cnt_q;
    assign err_frame  = ef_q;
    assign err_parity = ep_q;
    assign overrun    = ovr_q;

`ifdef UART_RX_BREAK_EN
    // Break length measured in oversampling ticks of continuous low line.
    localparam int BL = (DATA_BITS + 2 + (PARITY != 0 ? 1 : 0)) * OVS;
    localparam int BW = $clog2(BL + 1);

    logic [BW-1:0] bc_q, bc_d;
    logic          brk_q, brk_d;

    always_comb begin
        bc_d  = rx ? '0 : ((tick && bc_q != BW'(BL)) ? bc_q + 1'b1 : bc_q);
        brk_d = !rx && bc_q == BW'(BL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bc_q  <= '0;
            brk_q <= 1'b0;
        end else begin
            bc_q  <= bc_d;
            brk_q <= brk_d;
        end
    end

    assign brk = brk_q;
`else
    assign brk = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized checks of uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int BT = 160;
`ifdef UART_RX_BREAK_EN
    localparam logic BRK_EXP = 1'b1;
`else
    localparam logic BRK_EXP = 1'b0;
`endif

    logic       clk = 1'b0, rst = 1'b1;
    logic       rxd_a = 1'b1, rdy_a = 1'b0, clr_a = 1'b0;
    logic       rxd_p = 1'b1, rdy_p = 1'b0, clr_p = 1'b0;
    logic [7:0] d_a, d_p;
    logic [4:0] cnt_a, cnt_p;
    logic       vld_a, fe_a, pe_a, ovr_a, brk_a;
    logic       vld_p, fe_p, pe_p, ovr_p, brk_p;

    int errors = 0, checks = 0;
    int fe_n = 0, pe_n = 0, fe_pn = 0, pe_pn = 0, fe_exp = 0;
    logic [7:0] q [$];
    logic       ovr_exp = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLK_HZ(1536000), .BAUD(9600), .OVS(16), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(16)) u_dut (
        .clk(clk), .rst(rst), .rxd(rxd_a), .d_rx(d_a), .vld_rx(vld_a), .rdy_rx(rdy_a), .count(cnt_a),
        .err_frame(fe_a), .err_parity(pe_a), .overrun(ovr_a), .clr_err(clr_a), .brk(brk_a));

    uart_rx_fifo #(.CLK_HZ(1536000), .BAUD(9600), .OVS(16), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(16)) u_par (
        .clk(clk), .rst(rst), .rxd(rxd_p), .d_rx(d_p), .vld_rx(vld_p), .rdy_rx(rdy_p), .count(cnt_p),
        .err_frame(fe_p), .err_parity(pe_p), .overrun(ovr_p), .clr_err(clr_p), .brk(brk_p));

    // Cycles-high counters: a correct one-cycle pulse adds exactly one.
    always @(posedge clk) begin
        if (fe_a) fe_n <= fe_n + 1;
        if (pe_a) pe_n <= pe_n + 1;
        if (fe_p) fe_pn <= fe_pn + 1;
        if (pe_p) pe_pn <= pe_pn + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bit_a(input logic v);
        rxd_a = v;
        repeat (BT) @(negedge clk);
    endtask

    task automatic bit_p(input logic v);
        rxd_p = v;
        repeat (BT) @(negedge clk);
    endtask

    task automatic frame_a(input logic [7:0] b, input logic stop);
        bit_a(1'b0);
        for (int i = 0; i < 8; i++) bit_a(b[i]);
        bit_a(stop);
    endtask

    task automatic frame_p(input logic [7:0] b, input logic pbit);
        bit_p(1'b0);
        for (int i = 0; i < 8; i++) bit_p(b[i]);
        bit_p(pbit);
        bit_p(1'b1);
    endtask

    task automatic model_push(input logic [7:0] b);
        if (q.size() < 16) q.push_back(b);
        else ovr_exp = 1'b1;
    endtask

    task automatic pop_chk(input string tag);
        if (q.size() == 0) return;
        chk(tag, 32'(d_a), 32'(q[0]));
        void'(q.pop_front());
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
        chk({tag, "_cnt"}, 32'(cnt_a), q.size());
    endtask

    initial begin
        logic [7:0] b;
        logic       stop;
        repeat (3) @(negedge clk);
        chk("rst_vld", 32'(vld_a), 0);
        chk("rst_cnt", 32'(cnt_a), 0);
        chk("rst_d", 32'(d_a), 0);
        chk("rst_ovr", 32'(ovr_a), 0);
        chk("rst_err", 32'({fe_a, pe_a, brk_a}), 0);
        rst = 1'b0;
        repeat (BT) @(negedge clk);

        frame_a(8'hA5, 1'b1);
        model_push(8'hA5);
        chk("a5_vld", 32'(vld_a), 1);
        chk("a5_d", 32'(d_a), 32'h A5);
        chk("a5_cnt", 32'(cnt_a), 1);
        chk("a5_err", 32'(fe_n + pe_n), 0);
        pop_chk("a5_pop");
        chk("a5_vld_after", 32'(vld_a), 0);

        for (int i = 0; i < 17; i++) begin
            frame_a(8'(i), 1'b1);
            model_push(8'(i));
        end
        chk("full_cnt", 32'(cnt_a), 16);
        chk("full_ovr", 32'(ovr_a), 32'(ovr_exp));
        chk("full_head", 32'(d_a), 0);
        while (q.size() > 0) pop_chk("drain");
        chk("drain_vld", 32'(vld_a), 0);
        chk("drain_hold_d", 32'(d_a), 32'h0F);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        ovr_exp = 1'b0;
        chk("clr_ovr", 32'(ovr_a), 0);

        frame_p(8'h03, 1'b1);
        chk("par_bad_pulse", pe_pn, 1);
        chk("par_bad_cnt", 32'(cnt_p), 0);
        frame_p(8'h03, 1'b0);
        chk("par_ok_cnt", 32'(cnt_p), 1);
        chk("par_ok_d", 32'(d_p), 3);
        chk("par_ok_err", pe_pn + fe_pn, 1);

        frame_a(8'h5A, 1'b0);
        bit_a(1'b1);
        fe_exp = 1;
        chk("frm_pulse", fe_n, fe_exp);
        chk("frm_cnt", 32'(cnt_a), 0);
        frame_a(8'h5A, 1'b1);
        model_push(8'h5A);
        chk("frm_next_d", 32'(d_a), 32'h5A);
        pop_chk("frm_pop");

        rxd_a = 1'b0;
        repeat (30) @(negedge clk);
        rxd_a = 1'b1;
        repeat (2 * BT) @(negedge clk);
        chk("glitch_cnt", 32'(cnt_a), 0);
        chk("glitch_err", fe_n + pe_n, fe_exp);
        frame_a(8'h3C, 1'b1);
        model_push(8'h3C);
        chk("glitch_next_d", 32'(d_a), 32'h3C);
        chk("glitch_next_cnt", 32'(cnt_a), 1);

        bit_a(1'b0);
        bit_a(1'b1);
        bit_a(1'b0);
        rst = 1'b1;
        rxd_a = 1'b1;
        q.delete();
        repeat (2) @(negedge clk);
        chk("midrst_cnt", 32'(cnt_a), 0);
        chk("midrst_vld", 32'(vld_a), 0);
        rst = 1'b0;
        repeat (BT) @(negedge clk);
        frame_a(8'hC3, 1'b1);
        model_push(8'hC3);
        chk("midrst_next_d", 32'(d_a), 32'hC3);
        pop_chk("midrst_pop");

        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(0, 1) == 1) pop_chk("rnd_pop");
            b = 8'($urandom);
            stop = $urandom_range(0, 4) != 0;
            frame_a(b, stop);
            if (stop) model_push(b);
            else begin
                fe_exp++;
                bit_a(1'b1);
            end
            chk("rnd_cnt", 32'(cnt_a), q.size());
            chk("rnd_ovr", 32'(ovr_a), 32'(ovr_exp));
            chk("rnd_fe", fe_n, fe_exp);
            if (q.size() > 0) chk("rnd_head", 32'(d_a), 32'(q[0]));
        end
        while (q.size() > 0) pop_chk("rnd_drain");

        rxd_a = 1'b0;
        repeat (1520) @(negedge clk);
        chk("brk_early", 32'(brk_a), 0);
        repeat (180) @(negedge clk);
        chk("brk_on", 32'(brk_a), 32'(BRK_EXP));
        repeat (220) @(negedge clk);
        rxd_a = 1'b1;
        repeat (3) @(negedge clk);
        chk("brk_off", 32'(brk_a), 0);
        repeat (BT) @(negedge clk);
        chk("brk_fe", fe_n, fe_exp + 1);
        chk("brk_cnt", 32'(cnt_a), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised successor to the serial debug unit's fixed 9600-baud receive path: UART receiver plus receive FIFO.
- Runs directly on the system clock using an internal oversampling tick generator; no divided clock domain is needed.
- Configurable baud, oversampling, data width, parity and FIFO depth.
- Presents received characters to the debug command processor over the existing vld_rx/rdy_rx handshake, and reports framing, parity and overrun errors.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- OVS, 16, oversampling ticks per bit; even, >= 8.
- DATA_BITS, 8, character width, 5..8.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- FIFO_DEPTH, 16, receive FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- rxd  in  1  serial input, idle high, asynchronous to clk.
- d_rx  out  DATA_BITS  FIFO head character, first-word fall-through.
- vld_rx  out  1  FIFO non-empty.
- rdy_rx  in  1  consumer ready; a pop occurs when vld_rx && rdy_rx.
- count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- err_frame  out  1  one-cycle pulse: stop bit sampled 0.
- err_parity  out  1  one-cycle pulse: parity mismatch.
- overrun  out  1  sticky: character dropped because the FIFO was full.
- clr_err  in  1  clears overrun.
- brk  out  1  line-break indication; see Optional Feature.

Behaviour:
- Reset: all outputs 0; synchroniser stages 1; FSM IDLE; FIFO empty; tick counter 0. Reset mid-frame discards the partial character.
- Input sync: rxd passes through 2 flip-flops; all FSM decisions use the synchronised value.
- Tick generator:
  - DIV = round(CLK_HZ / (BAUD*OVS)), minimum 1.
  - Counter runs 0..DIV-1 and produces a 1-cycle tick at DIV-1.
  - Free-running; the phase counter (0..OVS-1) is cleared on entry to START.
- FSM states: IDLE, START, DATA, PAR, STOP, WAIT_HI.
  - IDLE: on synced rxd==0, go to START.
  - START: at tick OVS/2-1 (mid-bit), sample. If 1 (glitch), go to IDLE. If 0, go to DATA with bit index 0.
  - DATA: sample every OVS ticks, LSB first, into a shift register. After DATA_BITS samples, go to PAR if PARITY!=0, else STOP.
  - PAR: sample and compare against the XOR of the data bits (odd: XOR of data bits ^ 1). Record the result; go to STOP.
  - STOP, sample 1: if parity was OK, push the character; otherwise pulse err_parity and discard the character. Go to IDLE.
  - STOP, sample 0: pulse err_frame, discard the character, go to WAIT_HI.
  - WAIT_HI: return to IDLE when synced rxd==1.
- FIFO timing:
  - Push occurs in the cycle after the stop-bit sample.
  - vld_rx and d_rx are valid the cycle after the push.
  - Pointers wrap modulo FIFO_DEPTH.
- FIFO boundary cases:
  - Push while full with no pop: character dropped; overrun set. count stays FIFO_DEPTH and the head is unchanged.
  - Push and pop in the same cycle while full: both take effect; no overrun; count unchanged.
  - Push and pop in the same cycle otherwise: count unchanged.
  - Pop while empty: ignored.
- overrun clears on clr_err; set takes priority over clear in the same cycle.
- d_rx holds its last value when the FIFO is empty.

Optional Feature:
- Macro: UART_RX_BREAK_EN.
- When defined:
  - brk asserts once synced rxd has been continuously low for (DATA_BITS + 2 + (PARITY!=0)) bit times.
  - This counter is separate from the FSM; err_frame still pulses as normal.
  - brk deasserts on the first cycle synced rxd is 1.
- When undefined: brk is tied to 0 and no break counter is synthesised.

Test Plan:
- Setup for all cases: CLK_HZ=1536000, BAUD=9600, OVS=16 (DIV=10), DATA_BITS=8, PARITY=0, FIFO_DEPTH=16 unless noted.
- Send 0xA5 in 8N1 with rdy_rx=0 -> vld_rx=1, d_rx=0xA5, count=1, no error pulses. Raise rdy_rx for 1 cycle -> vld_rx=0, count=0.
- Send 17 bytes 0x00..0x10 with rdy_rx=0 -> count=16, overrun=1, d_rx=0x00. Pop all -> sequence 0x00..0x0F. Assert clr_err -> overrun=0.
- PARITY=2: send 0x03 with parity bit 1 -> err_parity pulses for 1 cycle, count=0. Send 0x03 with parity bit 0 -> accepted.
- Send 0x5A with stop bit 0, then line high -> err_frame pulses once, count=0. A following 0x5A frame is received correctly.
- Drive a 3-tick low glitch on rxd -> no push, no error pulses, FSM returns to IDLE. Assert rst mid-frame -> count=0, vld_rx=0; the next frame is received intact.
- With UART_RX_BREAK_EN: hold rxd low for 12 bit times -> brk=1 after 10 bit times and err_frame pulses once. rxd high -> brk=0 within 3 cycles.
